// File: rtl/fir_seq_pkg.sv
// fir_seq_pkg: shared states, default widths and Booth recoding for the FIR tap sequencer
package fir_seq_pkg;
  localparam int DW_DEF = 4;
  localparam int CW_DEF = 4;
  localparam int TAPS_DEF = 4;
  typedef enum logic [1:0] {IDLE, MUL, OUT} state_t;
  typedef enum logic [1:0] {B_NONE, B_ADD, B_SUB} booth_op_t;
  function automatic booth_op_t booth_recode(input logic [1:0] w);
    return w == 2'b01 ? B_ADD : w == 2'b10 ? B_SUB : B_NONE;
  endfunction
endpackage

// File: rtl/booth_mul_seq.sv
// booth_mul_seq: sequential radix-2 Booth multiplier, one load cycle plus CW iterations
module booth_mul_seq
  import fir_seq_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic signed [DW-1:0]    i_x,
  input  logic signed [CW-1:0]    i_c,
  output logic                    o_done,
  output logic signed [DW+CW-1:0] o_prod
);
  localparam int NW = $clog2(CW + 1);
  logic signed [DW:0] r_m, r_hi, w_hi;
  logic [CW-1:0] r_lo;
  logic r_q, r_run, r_done;
  logic [NW-1:0] r_cnt;
  booth_op_t w_op;
  // one guard bit on the high half keeps subtracting the most negative multiplicand exact
  always_comb begin
    w_op = booth_recode({r_lo[0], r_q});
    w_hi = w_op == B_ADD ? r_hi + r_m : w_op == B_SUB ? r_hi - r_m : r_hi;
  end
  // load operands on start, then add/sub and arithmetic-shift once per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m <= '0;
      r_hi <= '0;
      r_lo <= '0;
      r_q <= 1'b0;
      r_cnt <= '0;
      r_run <= 1'b0;
      r_done <= 1'b0;
    end else if (i_start) begin
      r_m <= {i_x[DW-1], i_x};
      r_hi <= '0;
      r_lo <= i_c;
      r_q <= 1'b0;
      r_cnt <= NW'(CW);
      r_run <= 1'b1;
      r_done <= 1'b0;
    end else begin
      r_done <= r_run && r_cnt == NW'(1);
      if (r_run) begin
        r_hi <= {w_hi[DW], w_hi[DW:1]};
        r_lo <= {w_hi[0], r_lo[CW-1:1]};
        r_q <= r_lo[0];
        r_cnt <= r_cnt - NW'(1);
        r_run <= r_cnt != NW'(1);
      end
    end
  end
  assign o_done = r_done;
  assign o_prod = {r_hi[DW-1:0], r_lo};
endmodule

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: time-multiplexed FIR controller sharing one Booth multiplier across all taps
module fir_tap_sequencer
  import fir_seq_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF,
  parameter int TAPS = TAPS_DEF,
  parameter int ACCW = DW + CW + $clog2(TAPS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [DW-1:0]        in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [ACCW-1:0]      out_data,
  input  logic                        cfg_we,
  input  logic [$clog2(TAPS):0]       cfg_addr,
  input  logic signed [CW-1:0]        cfg_data,
  output logic                        cfg_err,
  output logic                        busy
);
  localparam int IW = $clog2(TAPS);
  localparam int PW = DW + CW;
  state_t r_state, w_next;
  logic [IW-1:0] r_idx, w_sel;
  logic r_first, r_cfg_err;
  logic w_accept, w_start, w_done, w_last, w_cfg_ok;
  logic signed [DW-1:0] r_x [TAPS];
  logic signed [CW-1:0] r_coef [TAPS];
  logic signed [ACCW-1:0] r_acc, r_out, w_sum;
  logic signed [PW-1:0] w_prod;
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  // next state, handshake outputs and multiplier sequencing
  always_comb begin
    in_ready = r_state == IDLE;
    out_valid = r_state == OUT;
    busy = r_state == MUL;
    w_accept = in_valid && in_ready;
    w_last = r_idx == IW'(TAPS - 1);
    w_next = w_accept ? MUL
           : busy && w_done && w_last ? OUT
           : out_valid && out_ready ? IDLE
           : r_state;
    w_start = busy && (r_first || (w_done && !w_last));
    w_sel = r_first ? '0 : r_idx + IW'(1);
    w_sum = r_acc + {{(ACCW - PW){w_prod[PW-1]}}, w_prod};
    w_cfg_ok = cfg_we && !busy && cfg_addr < (IW + 1)'(TAPS);
  end
  // tap index, accumulator and held result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_first <= 1'b0;
      r_idx <= '0;
      r_acc <= '0;
      r_out <= '0;
    end else begin
      r_first <= w_accept;
      if (w_accept) begin
        r_idx <= '0;
        r_acc <= '0;
      end else if (busy && w_done) begin
        r_acc <= w_sum;
        if (w_last) r_out <= w_sum;
        else r_idx <= r_idx + IW'(1);
      end
    end
  end
  // sample delay line shifts once per accepted sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) r_x[k] <= '0;
    end else if (w_accept) begin
      r_x[0] <= in_data;
      for (int k = 1; k < TAPS; k++) r_x[k] <= r_x[k-1];
    end
  end
  // coefficient bank; rejected writes raise a one-cycle error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) r_coef[k] <= CW'(1);
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= cfg_we && !w_cfg_ok;
      if (w_cfg_ok) r_coef[cfg_addr[IW-1:0]] <= cfg_data;
    end
  end
  booth_mul_seq #(.DW(DW), .CW(CW)) u_mul (
    .clk(clk),
    .rst(rst),
    .i_start(w_start),
    .i_x(r_x[w_sel]),
    .i_c(r_coef[w_sel]),
    .o_done(w_done),
    .o_prod(w_prod)
  );
  assign out_data = r_out;
  assign cfg_err = r_cfg_err;
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb_fir_tap_sequencer: directed self-checking bench for the FIR tap sequencer
module tb_fir_tap_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready, out_valid, cfg_err, busy;
  logic out_ready = 1'b1;
  logic cfg_we = 1'b0;
  logic signed [3:0] in_data = '0;
  logic signed [3:0] cfg_data = '0;
  logic [2:0] cfg_addr = '0;
  logic signed [9:0] out_data;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  fir_tap_sequencer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err),
    .busy(busy)
  );
  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic signed [3:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data = d;
    while (!in_ready && n < 60) begin
      tick();
      n++;
    end
    chk("send_ready", in_ready, 1);
    tick();
    acc_cyc = cyc;
    in_valid = 1'b0;
  endtask
  task automatic expect_out(input string tag, input logic signed [9:0] exp);
    int n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, cyc - acc_cyc, 21);
    chk(tag, out_data, exp);
  endtask
  task automatic cfg(input logic [2:0] a, input logic signed [3:0] d, input logic err);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    tick();
    cfg_we = 1'b0;
    chk("cfg_err", cfg_err, err);
    tick();
    chk("cfg_err_clr", cfg_err, 0);
  endtask
  initial begin
    automatic int s1 [5] = '{3, 5, 7, 2, 1};
    automatic int e1 [5] = '{3, 8, 15, 17, 15};
    automatic int s2 [5] = '{1, 0, 0, 0, 0};
    automatic int e2 [5] = '{1, 2, -1, 0, 0};
    automatic int e3 [4] = '{64, 128, 192, 256};
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(4'(s1[i]));
      expect_out("b2b", 10'(e1[i]));
    end
    tick();
    chk("b2b_drop", out_valid, 0);
    chk("b2b_hold", out_data, 15);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cfg(0, 1, 0);
    cfg(1, 2, 0);
    cfg(2, -1, 0);
    cfg(3, 0, 0);
    for (int i = 0; i < 5; i++) begin
      send(4'(s2[i]));
      chk("imp_cfg_err", cfg_err, 0);
      expect_out("impulse", 10'(e2[i]));
    end
    tick();
    send(3);
    tick();
    chk("mul_busy", busy, 1);
    cfg(0, 5, 1);
    expect_out("mul_write", 3);
    tick();
    cfg(4, 5, 1);
    send(1);
    expect_out("bad_addr", 7);
    tick();
    out_ready = 1'b0;
    send(2);
    expect_out("bp", 1);
    in_valid = 1'b1;
    in_data = 4;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    cfg(0, 3, 0);
    chk("bp_cfg_data", out_data, 1);
    out_ready = 1'b1;
    tick();
    chk("bp_drop", out_valid, 0);
    chk("bp_retain", out_data, 1);
    chk("bp_ready", in_ready, 1);
    send(4);
    expect_out("bp2", 15);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) cfg(3'(k), -8, 0);
    for (int i = 0; i < 4; i++) begin
      send(-8);
      expect_out("extreme", 10'(e3[i]));
    end
    send(7);
    expect_out("extreme_mix", 136);
    tick();
    send(5);
    repeat (5) tick();
    chk("abort_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_ready", in_ready, 1);
    chk("abort_busy_clr", busy, 0);
    chk("abort_data", out_data, 0);
    tick();
    rst = 1'b0;
    send(4);
    expect_out("post_rst", 4);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
